// File: rtl/io_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_uart_rx
// Purpose  : Buffered 8N1 UART receiver on the CPU I/O bus. Frames from the
//            serial pin go into a receive FIFO. DATA and STATUS registers are
//            served with the run/done toggle handshake, qualified by a
//            rising edge of the sampled CPU clock.
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_rx #(
  parameter int          CLK_FREQ   = 27000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0002
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cpu_clk,
  input  logic [15:0] addr,
  input  logic [1:0]  cmd,
  input  logic        run,
  output logic [15:0] rd_data,
  output logic        done,
  input  logic        uart_rxp,
  output logic        rx_irq
);

  localparam int              c_BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int              c_CW          = $clog2(c_BIT_CYCLES);
  localparam int              c_AW          = $clog2(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_FULL_LOAD   = c_CW'(c_BIT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_HALF_LOAD   = c_CW'(c_BIT_CYCLES / 2 - 1);
  localparam logic [c_AW:0]   c_DEPTH       = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]     c_STATUS_ADDR = BASE_ADDR + 16'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Synchroniser, receiver and bus state
  logic            rx_meta_q, rxs_q, rxs_prev_q, cpu_clk_q;
  state_t          state_q, state_d;
  logic [c_CW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [c_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            done_q, done_d, rx_irq_q, rx_irq_d;

  logic            w_push, w_ferr_set, w_push_ok, w_ovr_set, w_pop;
  logic            w_cpu_rise, w_sel_data, w_sel_stat, w_xfer, w_is_read, w_stat_clr;
  logic            w_empty, w_full;
  logic [c_AW:0]   w_level;
  logic [7:0]      w_head;

  // Two-flop pin synchroniser, a third stage for falling-edge detect, and the CPU clock sampler
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      cpu_clk_q  <= 1'b1;
    end else begin
      rx_meta_q  <= uart_rxp;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      cpu_clk_q  <= cpu_clk;
    end
  end

  // Receiver state register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Receiver next state: half-bit delay to mid start bit, then one sample per bit period
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = c_HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            cnt_d   = c_FULL_LOAD;
            bit_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;  // start bit did not survive to mid-bit: glitch
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rxs_q, shreg_q[7:1]};
          cnt_d   = c_FULL_LOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            w_push = 1'b1;
          end else begin
            w_ferr_set = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus decode, FIFO bookkeeping and read-data mux
  always_comb begin
    w_level    = wr_ptr_q - rd_ptr_q;
    w_empty    = (wr_ptr_q == rd_ptr_q);
    w_full     = (w_level == c_DEPTH);
    w_head     = mem_q[rd_ptr_q[c_AW-1:0]];
    w_cpu_rise = cpu_clk & ~cpu_clk_q;
    w_sel_data = (addr == BASE_ADDR);
    w_sel_stat = (addr == c_STATUS_ADDR);
    w_xfer     = w_cpu_rise && (run != done_q) && (w_sel_data || w_sel_stat);
    w_is_read  = (cmd == 2'd0) || (cmd == 2'd2);
    w_pop      = w_xfer && w_is_read && w_sel_data && !w_empty;
    w_stat_clr = w_xfer && w_is_read && w_sel_stat;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    w_push_ok  = w_push && (!w_full || w_pop);
    w_ovr_set  = w_push && !w_push_ok;

    wr_ptr_d   = w_push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // Set beats clear when both land in the same cycle
    ovr_d      = (ovr_q & ~w_stat_clr) | w_ovr_set;
    ferr_d     = (ferr_q & ~w_stat_clr) | w_ferr_set;
    rx_irq_d   = (wr_ptr_d != rd_ptr_d);
    done_d     = w_xfer ? ~done_q : done_q;

    rd_data_d  = rd_data_q;
    if (w_xfer && w_is_read) begin
      if (w_sel_data) begin
        rd_data_d = w_empty ? 16'h0000 : {7'b0, 1'b1, w_head};
      end else begin
        rd_data_d = {8'(w_level), 4'b0, ferr_q, ovr_q, w_full, ~w_empty};
      end
    end
  end

  // FIFO pointers, sticky flags and bus outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rd_data_q <= 16'h0000;
      done_q    <= 1'b0;
      rx_irq_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      rx_irq_q  <= rx_irq_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge sysclk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= shreg_q;
    end
  end

  assign rd_data = rd_data_q;
  assign done    = done_q;
  assign rx_irq  = rx_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_rx
// Purpose  : Directed self-checking bench for io_uart_rx at default parameters
//            (234 sysclk cycles per bit, 16-entry FIFO, DATA at 0x0002).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_rx;

  localparam int          c_BIT    = 27000000 / 115200;
  localparam logic [15:0] c_DATA_A = 16'h0002;
  localparam logic [15:0] c_STAT_A = 16'h0004;

  logic        sysclk   = 1'b0;
  logic        reset    = 1'b1;
  logic        cpu_clk  = 1'b0;
  logic [15:0] addr     = 16'h0000;
  logic [1:0]  cmd      = 2'd0;
  logic        run      = 1'b0;
  logic        uart_rxp = 1'b1;
  logic [15:0] rd_data;
  logic        done;
  logic        rx_irq;

  int          checks   = 0;
  int          errors   = 0;
  logic        exp_done = 1'b0;
  logic [15:0] rdv;
  logic [15:0] rd_coll;

  always #5 sysclk = ~sysclk;

  io_uart_rx dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .cpu_clk  (cpu_clk),
    .addr     (addr),
    .cmd      (cmd),
    .run      (run),
    .rd_data  (rd_data),
    .done     (done),
    .uart_rxp (uart_rxp),
    .rx_irq   (rx_irq)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame; called on a negedge, returns on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxp = 1'b0;
    repeat (c_BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rxp = b[i];
      repeat (c_BIT) @(negedge sysclk);
    end
    uart_rxp = stop;
    repeat (c_BIT) @(negedge sysclk);
    uart_rxp = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  // One bus access: toggle run, then a single cpu_clk rising edge
  task automatic bus(input logic [15:0] a, input logic [1:0] c, input bit hit,
                     output logic [15:0] d);
    addr = a;
    cmd  = c;
    run  = ~run;
    repeat (2) @(negedge sysclk);
    cpu_clk = 1'b1;
    @(negedge sysclk);
    cpu_clk = 1'b0;
    @(negedge sysclk);
    d = rd_data;
    if (hit) exp_done = ~exp_done;
    else     run = ~run;  // withdraw the unclaimed request
    chk("done_toggle", 16'(done), 16'(exp_done));
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge sysclk);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_done", 16'(done), 16'h0000);
    chk("rst_irq", 16'(rx_irq), 16'h0000);
    reset = 1'b0;
    @(negedge sysclk);

    // run toggled with no cpu_clk edge: no acceptance
    addr = c_STAT_A;
    cmd  = 2'd0;
    run  = 1'b1;
    repeat (4) @(negedge sysclk);
    chk("no_rise_done", 16'(done), 16'h0000);
    cpu_clk = 1'b1;
    @(negedge sysclk);
    cpu_clk = 1'b0;
    exp_done = 1'b1;
    chk("rise_done", 16'(done), 16'h0001);
    chk("rst_status", rd_data, 16'h0000);
    // A second cpu_clk edge without a new run toggle does nothing
    repeat (2) @(negedge sysclk);
    cpu_clk = 1'b1;
    repeat (2) @(negedge sysclk);
    cpu_clk = 1'b0;
    chk("once_per_toggle", 16'(done), 16'h0001);

    // Single byte 0x41
    send_byte(8'h41, 1'b1);
    chk("irq_after_41", 16'(rx_irq), 16'h0001);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("stat_one", rdv, 16'h0101);
    bus(c_DATA_A, 2'd2, 1'b1, rdv); chk("data_41", rdv, 16'h0141);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("stat_empty", rdv, 16'h0000);
    chk("irq_fall", 16'(rx_irq), 16'h0000);

    // 17 bytes into a 16-deep FIFO: last one dropped, OVR set
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("stat_full_ovr", rdv, 16'h1007);
    for (int i = 0; i < 16; i++) begin
      bus(c_DATA_A, 2'd0, 1'b1, rdv);
      chk("data_seq", rdv, 16'h0100 + 16'(i));
    end
    bus(c_DATA_A, 2'd0, 1'b1, rdv); chk("data_empty", rdv, 16'h0000);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("ovr_cleared", rdv, 16'h0000);

    // Framing error, then a short glitch
    send_byte(8'h55, 1'b0);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("stat_ferr", rdv, 16'h0008);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("ferr_cleared", rdv, 16'h0000);
    uart_rxp = 1'b0;
    repeat (70) @(negedge sysclk);
    uart_rxp = 1'b1;
    repeat (400) @(negedge sysclk);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("glitch_ignored", rdv, 16'h0000);
    chk("glitch_irq", 16'(rx_irq), 16'h0000);

    // Stop-bit push lands in the same cycle as a DATA pop of the only entry
    send_byte(8'h3C, 1'b1);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        addr = c_DATA_A;
        cmd  = 2'd0;
        run  = ~run;
        repeat (2225) @(negedge sysclk);
        cpu_clk = 1'b1;
        @(negedge sysclk);
        cpu_clk = 1'b0;
        @(negedge sysclk);
        rd_coll = rd_data;
      end
    join
    exp_done = ~exp_done;
    chk("coll_done", 16'(done), 16'(exp_done));
    chk("coll_pop", rd_coll, 16'h013C);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("coll_level", rdv, 16'h0101);
    bus(c_DATA_A, 2'd0, 1'b1, rdv); chk("coll_new", rdv, 16'h01A5);

    // Writes toggle done only; foreign address is ignored
    bus(c_DATA_A, 2'd1, 1'b1, rdv); chk("wr_hold", rdv, 16'h01A5);
    bus(c_STAT_A, 2'd3, 1'b1, rdv); chk("wrb_hold", rdv, 16'h01A5);
    bus(16'h0000, 2'd0, 1'b0, rdv); chk("foreign_hold", rdv, 16'h01A5);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("after_wr", rdv, 16'h0000);

    // Reset mid-frame with one byte buffered
    send_byte(8'h77, 1'b1);
    chk("irq_before_rst", 16'(rx_irq), 16'h0001);
    uart_rxp = 1'b0;
    repeat (800) @(negedge sysclk);
    reset    = 1'b1;
    run      = 1'b0;
    uart_rxp = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("mid_rst_done", 16'(done), 16'h0000);
    chk("mid_rst_irq", 16'(rx_irq), 16'h0000);
    chk("mid_rst_rd", rd_data, 16'h0000);
    reset    = 1'b0;
    exp_done = 1'b0;
    repeat (3000) @(negedge sysclk);
    chk("no_partial_irq", 16'(rx_irq), 16'h0000);
    bus(c_STAT_A, 2'd0, 1'b1, rdv); chk("post_rst_stat", rdv, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
